// File: rtl/logic_alu_pkg.sv
// Shared definitions for the pipelined bitwise logic unit.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package logic_alu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_NOR    = 3'd2,
        OP_NAND   = 3'd3,
        OP_XOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_NOT_A  = 3'd6,
        OP_PASS_A = 3'd7
    } op_e;

endpackage

// File: rtl/logic_alu_core.sv
// Combinational W-bit two-operand logic function selected by op.
// Latency: 0 cycles (pure combinational, sits between the S1 and S2 registers).
// Backpressure: none; no state.
//
// Ports: op (operation select), a/b (operands), y (result).
module logic_alu_core
    import logic_alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [OP_W-1:0] op,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic [W-1:0]    y
);

    always_comb begin
        y = '0;
        case (op_e'(op))
            OP_AND:    y = a & b;
            OP_OR:     y = a | b;
            OP_NOR:    y = ~(a | b);
            OP_NAND:   y = ~(a & b);
            OP_XOR:    y = a ^ b;
            OP_XNOR:   y = ~(a ^ b);
            OP_NOT_A:  y = ~a;
            OP_PASS_A: y = a;
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/logic_alu_pipe.sv
// Two-stage registered bitwise logic unit: S1 input register, S2 result register.
// Latency: input presented in cycle c appears on result/out_valid in cycle c+2; 1 result/cycle.
// Backpressure: S2 holds while out_valid && !out_ready; in_ready drops once S1 is also full.
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready/op/a/b upstream handshake;
// out_valid/out_ready/result downstream handshake. With LOGIC_ALU_FLAGS_EN defined the
// zero and parity flag outputs are added, registered alongside result.
module logic_alu_pipe
    import logic_alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] op,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    result
`ifdef LOGIC_ALU_FLAGS_EN
    ,
    output logic            zero,
    output logic            parity
`endif
);

    // Set on the first clock after reset release; keeps in_ready low during
    // reset and for the remainder of the release cycle.
    logic            rst_done;

    logic            s1_v;
    logic [OP_W-1:0] s1_op;
    logic [W-1:0]    s1_a;
    logic [W-1:0]    s1_b;
    logic            s2_v;
    logic [W-1:0]    core_y;

    logic            s1_load;
    logic            s2_load;

    // Only combinational path through the unit: out_ready -> in_ready.
    assign in_ready  = rst_done & (~s1_v | ~s2_v | out_ready);
    assign s1_load   = in_valid & in_ready;
    assign s2_load   = s1_v & (~s2_v | out_ready);
    assign out_valid = s2_v;

    logic_alu_core #(.W(W)) u_core (
        .op (s1_op),
        .a  (s1_a),
        .b  (s1_b),
        .y  (core_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done <= 1'b0;
            s1_v     <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s2_v     <= 1'b0;
            result   <= '0;
        end else begin
            rst_done <= 1'b1;

            if (s1_load) begin
                s1_op <= op;
                s1_a  <= a;
                s1_b  <= b;
            end

            // A new accept refills S1 even while its old content moves to S2.
            if (s1_load)
                s1_v <= 1'b1;
            else if (s2_load)
                s1_v <= 1'b0;

            if (s2_load)
                result <= core_y;

            if (s2_load)
                s2_v <= 1'b1;
            else if (out_ready)
                s2_v <= 1'b0;
        end
    end

`ifdef LOGIC_ALU_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero   <= 1'b0;
            parity <= 1'b0;
        end else if (s2_load) begin
            zero   <= (core_y == '0);
            parity <= ^core_y;
        end
    end
`endif

endmodule

// File: tb/tb_logic_alu_pipe.sv
module tb_logic_alu_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // W=8 main instance
    logic       v8 = 0, ir8, ov8, ordy8 = 0;
    logic [2:0] op8 = 0;
    logic [7:0] a8 = 0, b8 = 0, res8;
    // W=1 and W=64 width-sweep instances
    logic        v1 = 0, ir1, ov1, ordy1 = 0;
    logic [2:0]  op1 = 0;
    logic [0:0]  a1 = 0, b1 = 0, res1;
    logic        v64 = 0, ir64, ov64, ordy64 = 0;
    logic [2:0]  op64 = 0;
    logic [63:0] a64 = 0, b64 = 0, res64;
`ifdef LOGIC_ALU_FLAGS_EN
    logic zero8, par8, zero1, par1, zero64, par64;
`endif

    logic_alu_pipe #(.W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .op(op8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(ordy8), .result(res8)
`ifdef LOGIC_ALU_FLAGS_EN
        , .zero(zero8), .parity(par8)
`endif
    );
    logic_alu_pipe #(.W(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(ir1), .op(op1), .a(a1), .b(b1),
        .out_valid(ov1), .out_ready(ordy1), .result(res1)
`ifdef LOGIC_ALU_FLAGS_EN
        , .zero(zero1), .parity(par1)
`endif
    );
    logic_alu_pipe #(.W(64)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(ir64), .op(op64), .a(a64), .b(b64),
        .out_valid(ov64), .out_ready(ordy64), .result(res64)
`ifdef LOGIC_ALU_FLAGS_EN
        , .zero(zero64), .parity(par64)
`endif
    );

    typedef struct {
        logic [7:0] res;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    int         n_assert = 0;
    int         n_fail = 0;
    int         n_emit = 0;
    int         cyc = 0;
    logic       check_lat = 0;
    logic       last_acc = 0;
    logic [7:0] exp_now = 0;

    function automatic logic [7:0] ref8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return ~(x | y);
            3'd3: return ~(x & y);
            3'd4: return x ^ y;
            3'd5: return ~(x ^ y);
            3'd6: return ~x;
            default: return x;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called just after a negedge with inputs already driven; evaluates the
    // handshakes that the coming posedge will act on, then advances one cycle.
    task automatic tick();
        exp_t e;
        #1;
        last_acc = v8 && ir8;
        if (last_acc) q.push_back('{exp_now, cyc});
        if (ov8 && ordy8) begin
            n_emit++;
            if (q.size() == 0) begin
                chk("spurious_out", 64'(ov8), 64'(0));
            end else begin
                e = q.pop_front();
                chk("result", 64'(res8), 64'(e.res));
                if (check_lat) chk("latency", 64'(cyc - e.cyc), 64'(2));
`ifdef LOGIC_ALU_FLAGS_EN
                chk("zero", 64'(zero8), 64'(e.res == 8'h00));
                chk("parity", 64'(par8), 64'(^e.res));
`endif
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    logic [7:0] ops_tab [8];
    logic [2:0] bp_op [4];
    logic [7:0] bp_a [4];
    logic [7:0] bp_b [4];

    initial begin
        int e0;
        int idx;
        logic [7:0] held;

        ops_tab = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h3A, 8'hC5};
        bp_op = '{3'd0, 3'd4, 3'd6, 3'd1};
        bp_a  = '{8'hF0, 8'h5A, 8'h81, 8'h12};
        bp_b  = '{8'h3C, 8'h0F, 8'h77, 8'h40};

        // ---- reset ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(ov8), 64'(0));
        chk("rst_result", 64'(res8), 64'(0));
        chk("rst_in_ready", 64'(ir8), 64'(0));
`ifdef LOGIC_ALU_FLAGS_EN
        chk("rst_zero", 64'(zero8), 64'(0));
        chk("rst_parity", 64'(par8), 64'(0));
`endif
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("in_ready_after_rst", 64'(ir8), 64'(1));
        @(negedge clk);

        // ---- all ops, back-to-back ----
        check_lat = 1;
        ordy8 = 1;
        e0 = n_emit;
        for (int i = 0; i < 8; i++) begin
            v8 = 1; op8 = 3'(i); a8 = 8'hC5; b8 = 8'h3A; exp_now = ops_tab[i];
            tick();
        end
        v8 = 0;
        repeat (4) tick();
        chk("allops_count", 64'(n_emit - e0), 64'(8));

        // ---- backpressure ----
        check_lat = 0;
        ordy8 = 0;
        e0 = n_emit;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            v8 = 1; op8 = bp_op[idx]; a8 = bp_a[idx]; b8 = bp_b[idx];
            exp_now = ref8(op8, a8, b8);
            tick();
            if (last_acc) idx++;
        end
        #1;
        chk("bp_accepted", 64'(idx), 64'(2));
        chk("bp_in_ready", 64'(ir8), 64'(0));
        chk("bp_out_valid", 64'(ov8), 64'(1));
        held = ref8(bp_op[0], bp_a[0], bp_b[0]);
        chk("bp_hold", 64'(res8), 64'(held));
        @(negedge clk);
        ordy8 = 1;
        for (int c = 0; c < 10; c++) begin
            if (idx < 4) begin
                v8 = 1; op8 = bp_op[idx]; a8 = bp_a[idx]; b8 = bp_b[idx];
                exp_now = ref8(op8, a8, b8);
            end else begin
                v8 = 0;
            end
            tick();
            if (last_acc) idx++;
        end
        chk("bp_count", 64'(n_emit - e0), 64'(4));
        chk("bp_queue_empty", 64'(q.size()), 64'(0));

        // ---- random stream, simultaneous accept/emit ----
        check_lat = 1;
        e0 = n_emit;
        for (int i = 0; i < 16; i++) begin
            v8 = 1; op8 = 3'($urandom_range(0, 7));
            a8 = 8'($urandom); b8 = 8'($urandom);
            exp_now = ref8(op8, a8, b8);
            tick();
        end
        v8 = 0;
        repeat (4) tick();
        chk("rand_count", 64'(n_emit - e0), 64'(16));

        // ---- reset mid-stream ----
        check_lat = 0;
        ordy8 = 0;
        for (int i = 0; i < 3; i++) begin
            v8 = 1; op8 = 3'd7; a8 = 8'(8'hA0 + i); b8 = 0; exp_now = a8;
            tick();
        end
        v8 = 0;
        #1;
        chk("mid_full_valid", 64'(ov8), 64'(1));
        chk("mid_full_ready", 64'(ir8), 64'(0));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(ov8), 64'(0));
        chk("mid_rst_ready", 64'(ir8), 64'(0));
        chk("mid_rst_result", 64'(res8), 64'(0));
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ordy8 = 1;
        e0 = n_emit;
        repeat (5) tick();
        chk("mid_no_stale", 64'(n_emit - e0), 64'(0));
        #1;
        chk("mid_valid_low", 64'(ov8), 64'(0));
        @(negedge clk);

        // ---- width sweep: NOR of zeros ----
        v1 = 1; op1 = 3'd2; a1 = 0; b1 = 0; ordy1 = 1;
        v64 = 1; op64 = 3'd2; a64 = 0; b64 = 0; ordy64 = 1;
        #1;
        chk("w1_in_ready", 64'(ir1), 64'(1));
        chk("w64_in_ready", 64'(ir64), 64'(1));
        @(negedge clk);
        v1 = 0; v64 = 0;
        @(negedge clk);
        #1;
        chk("w1_valid", 64'(ov1), 64'(1));
        chk("w1_result", 64'(res1), 64'(1));
        chk("w64_valid", 64'(ov64), 64'(1));
        chk("w64_result", res64, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef LOGIC_ALU_FLAGS_EN
        chk("w1_parity", 64'(par1), 64'(1));
        chk("w64_parity", 64'(par64), 64'(0));
        chk("w1_zero", 64'(zero1), 64'(0));
        chk("w64_zero", 64'(zero64), 64'(0));
`endif
        @(negedge clk);
        #1;
        chk("w64_drained", 64'(ov64), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
